// File: rtl/calc_stack.sv
// Button-driven accumulator calculator with a circular undo history.
// Buttons are synchronised; the execute/clear edges commit two clocks after first sampling.
module calc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       btnu,
  input  logic                       btnd,
  input  logic                       btnl,
  input  logic                       btnc,
  input  logic                       btnr,
  input  logic [WIDTH-1:0]           sw,
  output logic [WIDTH-1:0]           led,
  output logic                       ovf,
  output logic                       undo_err,
  output logic [$clog2(DEPTH+1)-1:0] hist_cnt
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, EXEC} state_t;

  // Bit order: {btnu, btnd, btnl, btnc, btnr}
  logic [4:0]       sync1_q, sync2_q;
  logic             up_prev_q, dn_prev_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] hist_q [DEPTH];
  logic             push;

  logic             clr_pulse, exe_pulse;
  logic [2:0]       op;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [PW-1:0]    ptr_inc, ptr_dec;

  assign clr_pulse = sync2_q[4] & ~up_prev_q;
  assign exe_pulse = sync2_q[3] & ~dn_prev_q;
  assign op        = sync2_q[2:0];
  assign ptr_inc   = (ptr_q == PW'(DEPTH-1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec   = (ptr_q == '0) ? PW'(DEPTH-1) : ptr_q - PW'(1);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      3'b000: begin
        res     = acc_q + sw;
        res_ovf = (acc_q[WIDTH-1] == sw[WIDTH-1]) && (res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      3'b001: begin
        res     = acc_q - sw;
        res_ovf = (acc_q[WIDTH-1] != sw[WIDTH-1]) && (res[WIDTH-1] != acc_q[WIDTH-1]);
      end
      3'b010:  res = acc_q & sw;
      3'b011:  res = acc_q | sw;
      3'b100:  res = acc_q ^ sw;
      3'b101:  res = ($signed(acc_q) < $signed(sw)) ? WIDTH'(1) : '0;
      3'b110:  res = acc_q << sw[SW-1:0];
      default: res = acc_q;
    endcase
  end

  // The commit lands on the IDLE->EXEC edge so the result appears two clocks after sampling;
  // the following EXEC cycle is a dead cycle that swallows any further execute pulse.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    if (clr_pulse) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exe_pulse) begin
            state_d = EXEC;
            ovf_d   = 1'b0;
            if (op == 3'b111) begin
              if (cnt_q != '0) begin
                acc_d = hist_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else begin
              push  = 1'b1;
              acc_d = res;
              ovf_d = res_ovf;
              ptr_d = ptr_inc;
              cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      state_q   <= IDLE;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      sync1_q   <= {btnu, btnd, btnl, btnc, btnr};
      sync2_q   <= sync1_q;
      up_prev_q <= sync2_q[4];
      dn_prev_q <= sync2_q[3];
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      if (push) hist_q[ptr_q] <= acc_q;
    end
  end

  assign led      = acc_q;
  assign ovf      = ovf_q;
  assign undo_err = err_q;
  assign hist_cnt = cnt_q;
endmodule
